bram_access_arbiter: RTL and testbench

Single-clock, two-requester arbiter that shares one unidirectional dual-port block RAM (one write port, one read port). Writes are steered to the RAM write port and reads to the RAM read port. Each port has its own round-robin arbitration, so one write and one read can issue in the same cycle. The block sits between two client engines and the RAM instance; the RAM is instantiated outside this block and wired with both its clocks tied to `clk`.

---
 rtl/bram_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_bram_access_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_access_arbiter.sv
// -----------------------------------------------------------------------------
// bram_access_arbiter
//
// Shares one simple dual-port block RAM (one write port, one read port)
// between two client engines. Writes go to the RAM write port and reads to
// the RAM read port. Each port has its own round-robin arbiter, so a write
// and a read can issue in the same cycle.
//
// The RAM lives outside this block, with both its clocks tied to clk. Its
// read output is registered. A read granted in cycle T returns data in T+1,
// and the response is tagged to the requester that issued it.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready      request handshake per requester
//                                (ready is combinational)
//   reqN_write                   1 = write, 0 = read
//   reqN_addr / reqN_wdata       request address and write data
//   rspN_valid                   read response valid for requester N
//                                (registered)
//   rsp_data                     shared read data (RAM output, pass-through)
//   bram_write_*                 RAM write port drive
//   bram_read_enable/_addr       RAM read port drive
//   bram_read_data               RAM registered read output
// -----------------------------------------------------------------------------
module bram_access_arbiter #(
  parameter int DATA = 32,
  parameter int ADDR = 7
) (
  input  logic            clk,
  input  logic            reset_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_write,
  input  logic [ADDR-1:0] req0_addr,
  input  logic [DATA-1:0] req0_wdata,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_write,
  input  logic [ADDR-1:0] req1_addr,
  input  logic [DATA-1:0] req1_wdata,

  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [DATA-1:0] rsp_data,

  output logic            bram_write_enable,
  output logic [ADDR-1:0] bram_write_addr,
  output logic [DATA-1:0] bram_write_data,
  output logic            bram_read_enable,
  output logic [ADDR-1:0] bram_read_addr,
  input  logic [DATA-1:0] bram_read_data
);

  // Priority pointers: 0 = requester 0 wins the next contest on that port.
  logic wr_prio;
  logic rd_prio;

  // Outstanding read response and the requester it belongs to.
  logic rsp_pending;
  logic rsp_owner;

  logic wr_cand0, wr_cand1, rd_cand0, rd_cand1;
  logic wr_gnt0,  wr_gnt1,  rd_gnt0,  rd_gnt1;
  logic wr_contest, rd_contest;

  // Candidates are masked by reset_n. While reset is asserted, no grant,
  // ready or RAM enable can be raised, whatever the valids are doing.
  assign wr_cand0 = reset_n && req0_valid &&  req0_write;
  assign wr_cand1 = reset_n && req1_valid &&  req1_write;
  assign rd_cand0 = reset_n && req0_valid && !req0_write;
  assign rd_cand1 = reset_n && req1_valid && !req1_write;

  assign wr_contest = wr_cand0 && wr_cand1;
  assign rd_contest = rd_cand0 && rd_cand1;

  // A lone candidate always wins. Under contest, the priority pointer decides.
  assign wr_gnt0 = wr_cand0 && (!wr_cand1 || !wr_prio);
  assign wr_gnt1 = wr_cand1 && (!wr_cand0 ||  wr_prio);
  assign rd_gnt0 = rd_cand0 && (!rd_cand1 || !rd_prio);
  assign rd_gnt1 = rd_cand1 && (!rd_cand0 ||  rd_prio);

  // A requester issues one request per cycle, so at most one of its two
  // grants can be set.
  assign req0_ready = wr_gnt0 || rd_gnt0;
  assign req1_ready = wr_gnt1 || rd_gnt1;

  // RAM port steering. Addr/data are forced to zero when the port is idle.
  always_comb begin
    // NOTE: every output gets a default before the if-chain; otherwise a path
    // that assigns nothing would infer a latch instead of a mux.
    bram_write_enable = wr_gnt0 || wr_gnt1;
    bram_write_addr   = '0;
    bram_write_data   = '0;
    if (wr_gnt0) begin
      bram_write_addr = req0_addr;
      bram_write_data = req0_wdata;
    end else if (wr_gnt1) begin
      bram_write_addr = req1_addr;
      bram_write_data = req1_wdata;
    end
  end

  always_comb begin
    bram_read_enable = rd_gnt0 || rd_gnt1;
    bram_read_addr   = '0;
    if (rd_gnt0) begin
      bram_read_addr = req0_addr;
    end else if (rd_gnt1) begin
      bram_read_addr = req1_addr;
    end
  end

  // State updates. A priority pointer only moves after a contested grant,
  // so an uncontested requester never steals a turn. The response tag
  // follows the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prio     <= 1'b0;
      rd_prio     <= 1'b0;
      rsp_pending <= 1'b0;
      rsp_owner   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling its
      // pre-edge value, independent of statement order in this block.
      if (wr_contest) begin
        wr_prio <= !wr_prio;
      end
      if (rd_contest) begin
        rd_prio <= !rd_prio;
      end
      rsp_pending <= rd_gnt0 || rd_gnt1;
      if (rd_gnt0 || rd_gnt1) begin
        rsp_owner <= rd_gnt1;
      end
    end
  end

  assign rsp0_valid = rsp_pending && !rsp_owner;
  assign rsp1_valid = rsp_pending &&  rsp_owner;

  // The RAM output is already registered, so it is passed straight through.
  // Same-cycle write/read hazards resolve in the RAM as read-before-write.
  assign rsp_data = bram_read_data;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for bram_access_arbiter.
// Contains a behavioural RAM with a registered, read-before-write read port,
// plus a transaction-level reference model. The model keeps per-port
// priority, expected memory contents and the expected next response.
// -----------------------------------------------------------------------------
module tb_bram_access_arbiter;

  localparam int DATA = 32;
  localparam int ADDR = 7;

  typedef struct packed {
    logic            v;
    logic            w;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] data;
  } req_t;

  typedef struct {
    req_t            r0;
    req_t            r1;
    logic [1:0]      rdy;   // {req1_ready, req0_ready}
    logic [1:0]      rsp;   // {rsp1_valid, rsp0_valid} seen in this cycle
    logic [DATA-1:0] data;  // rsp_data when rsp != 0
  } vec_t;

  localparam req_t IDLE = '0;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req0_valid = 1'b0, req0_write = 1'b0;
  logic            req1_valid = 1'b0, req1_write = 1'b0;
  logic [ADDR-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA-1:0] req0_wdata = '0, req1_wdata = '0;
  logic            req0_ready, req1_ready;
  logic            rsp0_valid, rsp1_valid;
  logic [DATA-1:0] rsp_data;
  logic            bram_write_enable, bram_read_enable;
  logic [ADDR-1:0] bram_write_addr, bram_read_addr;
  logic [DATA-1:0] bram_write_data, bram_read_data;

  always #5 clk = ~clk;

  bram_access_arbiter #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_write        (req0_write),
    .req0_addr         (req0_addr),
    .req0_wdata        (req0_wdata),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_write        (req1_write),
    .req1_addr         (req1_addr),
    .req1_wdata        (req1_wdata),
    .rsp0_valid        (rsp0_valid),
    .rsp1_valid        (rsp1_valid),
    .rsp_data          (rsp_data),
    .bram_write_enable (bram_write_enable),
    .bram_write_addr   (bram_write_addr),
    .bram_write_data   (bram_write_data),
    .bram_read_enable  (bram_read_enable),
    .bram_read_addr    (bram_read_addr),
    .bram_read_data    (bram_read_data)
  );

  // External simple dual-port RAM: synchronous write, registered read,
  // read-before-write on an address collision.
  logic [DATA-1:0] ram [1 << ADDR];
  logic [DATA-1:0] ram_q;
  always @(posedge clk) begin
    if (bram_write_enable) ram[bram_write_addr] <= bram_write_data;
    if (bram_read_enable)  ram_q <= ram[bram_read_addr];
  end
  assign bram_read_data = ram_q;

  // ---------------- reference model ----------------
  int              checks = 0;
  int              failures = 0;
  int              m_wr_p, m_rd_p;          // whose turn under contention
  int              m_wwin, m_rwin;          // winner this cycle, -1 = none
  bit              m_wcont, m_rcont;
  int              m_rsp_own = -1;          // expected responder this cycle
  logic [DATA-1:0] m_rsp_data = '0;
  logic [DATA-1:0] m_mem [1 << ADDR];

  task automatic check(input string name, input logic [DATA-1:0] act,
                       input logic [DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_p    = 0;
    m_rd_p    = 0;
    m_rsp_own = -1;
  endtask

  task automatic apply(input req_t r0, input req_t r1);
    req0_valid = r0.v; req0_write = r0.w; req0_addr = r0.addr; req0_wdata = r0.data;
    req1_valid = r1.v; req1_write = r1.w; req1_addr = r1.addr; req1_wdata = r1.data;
  endtask

  // Pick the winner among the requesters that want a port. A lone one wins;
  // if both want it, the one whose turn it is wins.
  function automatic int pick(input bit want0, input bit want1, input int turn);
    if (want0 && want1) return turn;
    if (want0) return 0;
    if (want1) return 1;
    return -1;
  endfunction

  task automatic model_eval();
    bit w0, w1, r0, r1;
    w0 = req0_valid && req0_write;   r0 = req0_valid && !req0_write;
    w1 = req1_valid && req1_write;   r1 = req1_valid && !req1_write;
    m_wcont = w0 && w1;
    m_rcont = r0 && r1;
    m_wwin  = pick(w0, w1, m_wr_p);
    m_rwin  = pick(r0, r1, m_rd_p);
  endtask

  task automatic model_commit();
    if (m_rwin >= 0) begin
      m_rsp_own  = m_rwin;
      m_rsp_data = m_mem[(m_rwin == 0) ? req0_addr : req1_addr];  // old contents
    end else begin
      m_rsp_own = -1;
    end
    if (m_wwin == 0) m_mem[req0_addr] = req0_wdata;
    if (m_wwin == 1) m_mem[req1_addr] = req1_wdata;
    if (m_wcont) m_wr_p = 1 - m_wr_p;
    if (m_rcont) m_rd_p = 1 - m_rd_p;
  endtask

  task automatic compare_model(input string tag);
    logic [ADDR-1:0] ewa, era;
    logic [DATA-1:0] ewd;
    ewa = (m_wwin == 0) ? req0_addr : (m_wwin == 1) ? req1_addr : '0;
    ewd = (m_wwin == 0) ? req0_wdata : (m_wwin == 1) ? req1_wdata : '0;
    era = (m_rwin == 0) ? req0_addr : (m_rwin == 1) ? req1_addr : '0;
    check({tag, ".ready"}, {30'd0, req1_ready, req0_ready},
          {30'd0, (m_wwin == 1 || m_rwin == 1), (m_wwin == 0 || m_rwin == 0)});
    check({tag, ".wen"},   {31'd0, bram_write_enable}, {31'd0, m_wwin >= 0});
    check({tag, ".waddr"}, {25'd0, bram_write_addr}, {25'd0, ewa});
    check({tag, ".wdata"}, bram_write_data, ewd);
    check({tag, ".ren"},   {31'd0, bram_read_enable}, {31'd0, m_rwin >= 0});
    check({tag, ".raddr"}, {25'd0, bram_read_addr}, {25'd0, era});
    check({tag, ".rspv"},  {30'd0, rsp1_valid, rsp0_valid},
          {30'd0, m_rsp_own == 1, m_rsp_own == 0});
    if (m_rsp_own >= 0) check({tag, ".rdata"}, rsp_data, m_rsp_data);
  endtask

  // One cycle: inputs are already driven (posedge+1). Sample at negedge,
  // then advance the model across the edge.
  task automatic step(input string tag, input bit use_tbl, input logic [1:0] t_rdy,
                      input logic [1:0] t_rsp, input logic [DATA-1:0] t_data);
    @(negedge clk);
    model_eval();
    compare_model(tag);
    if (use_tbl) begin
      check({tag, ".tbl_rdy"}, {30'd0, req1_ready, req0_ready}, {30'd0, t_rdy});
      check({tag, ".tbl_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, {30'd0, t_rsp});
      if (t_rsp != 2'b00) check({tag, ".tbl_data"}, rsp_data, t_data);
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    check({tag, ".bram"},
          {bram_write_enable, bram_read_enable, 30'd0} | {25'd0, bram_write_addr}
          | {25'd0, bram_read_addr} | bram_write_data, 32'd0);
    check({tag, ".rspv"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  // Pulse reset: assert at a negedge, release at the next negedge, then
  // let one idle posedge pass so stimulus resumes at posedge+1.
  task automatic do_reset();
    apply(IDLE, IDLE);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t wr(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    return '{1'b1, 1'b1, a, d};
  endfunction
  function automatic req_t rd(input logic [ADDR-1:0] a);
    return '{1'b1, 1'b0, a, 32'h0};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.v    = ($urandom_range(0, 9) < 7);
    r.w    = 1'($urandom_range(0, 1));
    r.addr = 7'($urandom_range(0, 15));
    r.data = $urandom;
    return r;
  endfunction

  vec_t tbl [21];

  initial begin
    req_t cur0, cur1;
    bit   g0, g1;

    tbl[0]  = '{wr(7'd5, 32'hDEADBEEF), IDLE, 2'b01, 2'b00, 32'h0};
    tbl[1]  = '{IDLE, rd(7'd5),               2'b10, 2'b00, 32'h0};
    tbl[2]  = '{IDLE, IDLE,                   2'b00, 2'b10, 32'hDEADBEEF};
    tbl[3]  = '{wr(7'd0, 32'h100), wr(7'd10, 32'h200), 2'b01, 2'b00, 32'h0};
    tbl[4]  = '{wr(7'd1, 32'h101), wr(7'd10, 32'h200), 2'b10, 2'b00, 32'h0};
    tbl[5]  = '{wr(7'd1, 32'h101), wr(7'd11, 32'h201), 2'b01, 2'b00, 32'h0};
    tbl[6]  = '{wr(7'd2, 32'h102), wr(7'd11, 32'h201), 2'b10, 2'b00, 32'h0};
    tbl[7]  = '{wr(7'd2, 32'h102), wr(7'd12, 32'h202), 2'b01, 2'b00, 32'h0};
    tbl[8]  = '{IDLE,              wr(7'd12, 32'h202), 2'b10, 2'b00, 32'h0};
    tbl[9]  = '{wr(7'd3, 32'h11),  IDLE,               2'b01, 2'b00, 32'h0};
    tbl[10] = '{rd(7'd3),          wr(7'd3, 32'h22),   2'b11, 2'b00, 32'h0};
    tbl[11] = '{IDLE, IDLE,                            2'b00, 2'b01, 32'h11};
    tbl[12] = '{rd(7'd0), rd(7'd10),                   2'b01, 2'b00, 32'h0};
    tbl[13] = '{rd(7'd1), rd(7'd10),                   2'b10, 2'b01, 32'h100};
    tbl[14] = '{rd(7'd1), rd(7'd11),                   2'b01, 2'b10, 32'h200};
    tbl[15] = '{rd(7'd2), rd(7'd11),                   2'b10, 2'b01, 32'h101};
    tbl[16] = '{rd(7'd2), rd(7'd12),                   2'b01, 2'b10, 32'h201};
    tbl[17] = '{rd(7'd3), rd(7'd12),                   2'b10, 2'b01, 32'h102};
    tbl[18] = '{rd(7'd3), IDLE,                        2'b01, 2'b10, 32'h202};
    tbl[19] = '{IDLE, IDLE,                            2'b00, 2'b01, 32'h22};
    tbl[20] = '{IDLE, IDLE,                            2'b00, 2'b00, 32'h0};

    for (int i = 0; i < (1 << ADDR); i++) m_mem[i] = '0;
    model_reset();

    // Reset held with both requesters pushing writes: everything stays quiet.
    apply(wr(7'd0, 32'hAAAA), wr(7'd1, 32'hBBBB));
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // That posedge already had the contest visible; the model must see it too.
    // Restart cleanly from a fresh reset so the first contest is checked.
    do_reset();
    apply(wr(7'd0, 32'hAAAA), wr(7'd1, 32'hBBBB));
    step("rel_contest", 1'b1, 2'b01, 2'b00, 32'h0);
    apply(IDLE, wr(7'd1, 32'hBBBB));
    step("rel_second", 1'b1, 2'b10, 2'b00, 32'h0);

    // Fill the whole RAM through the arbiter so every address has known contents.
    for (int a = 0; a < (1 << ADDR); a++) begin
      apply(wr(7'(a), 32'hA5A5_0000 | 32'(a)), IDLE);
      step("fill", 1'b0, 2'b00, 2'b00, 32'h0);
    end

    do_reset();
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].r0, tbl[i].r1);
      step($sformatf("vec%0d", i), 1'b1, tbl[i].rdy, tbl[i].rsp, tbl[i].data);
    end

    // Random traffic. A request that was not granted is held unchanged.
    cur0 = IDLE;
    cur1 = IDLE;
    for (int n = 0; n < 1500; n++) begin
      apply(cur0, cur1);
      step("rnd", 1'b0, 2'b00, 2'b00, 32'h0);
      g0 = (m_wwin == 0) || (m_rwin == 0);
      g1 = (m_wwin == 1) || (m_rwin == 1);
      if (!cur0.v || g0) cur0 = rand_req();
      if (!cur1.v || g1) cur1 = rand_req();
    end
    apply(IDLE, IDLE);
    step("rnd_drain", 1'b0, 2'b00, 2'b00, 32'h0);

    // Reset during a read grant: the response must never appear.
    do_reset();
    apply(wr(7'd7, 32'h77), IDLE);       // contest-free write to move nothing
    step("mid_pre", 1'b1, 2'b01, 2'b00, 32'h0);
    apply(rd(7'd7), IDLE);
    @(negedge clk);
    check("mid_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst_edge");
    reset_n = 1'b1;
    model_reset();
    apply(IDLE, IDLE);
    @(posedge clk);
    #1;
    step("mid_after", 1'b1, 2'b00, 2'b00, 32'h0);
    apply(wr(7'd8, 32'h88), wr(7'd9, 32'h99));
    step("mid_wprio", 1'b1, 2'b01, 2'b00, 32'h0);
    apply(rd(7'd7), rd(7'd8));
    step("mid_rprio", 1'b1, 2'b01, 2'b00, 32'h0);
    apply(IDLE, IDLE);
    step("mid_rsp", 1'b1, 2'b00, 2'b01, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
